// File: rtl/Modules_pkg.sv
// Shared types and constants for the MicroGT-01 floating-point datapath.
package Modules_pkg;

   // IEEE-754 single-precision word.
   typedef struct packed {
      logic        sign;
      logic [7:0]  exponent;
      logic [22:0] mantissa;
   } float_t;

   // RISC-V rounding modes; 101/110/111 are reserved encodings.
   typedef enum logic [2:0] {
      RNE = 3'b000,
      RTZ = 3'b001,
      RDN = 3'b010,
      RUP = 3'b011,
      RMM = 3'b100
   } rnd_mode_t;

   // RISC-V fflags layout, MSB first.
   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } fflags_t;

   localparam float_t      CANO_NAN   = float_t'(32'h7FC0_0000);
   localparam float_t      P_INFTY    = float_t'(32'h7F80_0000);
   localparam float_t      N_INFTY    = float_t'(32'hFF80_0000);
   localparam logic [30:0] MAX_FINITE = 31'h7F7F_FFFF;

endpackage

// File: rtl/fp_round_decide.sv
// Combinational round-up decision from sign, mantissa LSB, G/R/S and rounding mode.
module fp_round_decide
   import Modules_pkg::*;
(
   input  logic       sign_i,
   input  logic       lsb_i,
   input  logic [2:0] grs_i,
   input  rnd_mode_t  round_mode_i,
   output logic       inc_o
);

   logic ix;

   // Select the increment rule for the active rounding mode.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
      inc_o = 1'b0;
      ix    = |grs_i;
      case (round_mode_i)
         RNE:     inc_o = grs_i[2] & (grs_i[1] | grs_i[0] | lsb_i);
         RTZ:     inc_o = 1'b0;
         RDN:     inc_o = sign_i & ix;
         RUP:     inc_o = ~sign_i & ix;
         RMM:     inc_o = grs_i[2];
         default: inc_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/fp_round_unit.sv
// Two-stage IEEE-754 rounding stage with exception flags and sticky fflags accumulator.
module fp_round_unit
   import Modules_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       clk_en_i,
   input  logic       valid_i,
   input  float_t     to_round_unit_i,
   input  logic [2:0] grs_i,
   input  rnd_mode_t  round_mode_i,
   input  logic       invalid_op_i,
   input  logic       div_zero_i,
   input  logic       overflow_i,
   input  logic       underflow_i,
   input  logic       clear_flags_i,
   output float_t     result_o,
   output logic       valid_o,
   output fflags_t    fflags_o,
   output fflags_t    fflags_acc_o,
   output logic       illegal_rm_o
);

   // Stage 1: operand, G/R/S, mode, upstream flags {nv, dz, of, uf}, increment decision.
   logic       s1_valid_q, s1_valid_d;
   float_t     s1_op_q,    s1_op_d;
   logic [2:0] s1_grs_q,   s1_grs_d;
   rnd_mode_t  s1_rm_q,    s1_rm_d;
   logic [3:0] s1_exc_q,   s1_exc_d;
   logic       s1_inc_q,   s1_inc_d;
   logic       inc_w;

   // Stage 2: rounded result and flags, driven straight to the outputs.
   logic       valid_q,    valid_d;
   float_t     result_q,   result_d;
   fflags_t    fflags_q,   fflags_d;
   fflags_t    acc_q,      acc_d;
   logic       illegal_q,  illegal_d;

   // Stage-2 combinational intermediates.
   logic [23:0] mant_sum;
   logic [7:0]  exp_rnd;
   logic        ix, bypass, illegal, ovf, to_inf;
   float_t      res_new;
   fflags_t     flags_new;

   fp_round_decide u_decide (
      .sign_i       (to_round_unit_i.sign),
      .lsb_i        (to_round_unit_i.mantissa[0]),
      .grs_i        (grs_i),
      .round_mode_i (round_mode_i),
      .inc_o        (inc_w)
   );

   // Stage-1 next state: capture inputs when the pipeline advances, else hold.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_op_d    = s1_op_q;
      s1_grs_d   = s1_grs_q;
      s1_rm_d    = s1_rm_q;
      s1_exc_d   = s1_exc_q;
      s1_inc_d   = s1_inc_q;
      if (clk_en_i) begin
         s1_valid_d = valid_i;
         s1_op_d    = to_round_unit_i;
         s1_grs_d   = grs_i;
         s1_rm_d    = round_mode_i;
         s1_exc_d   = {invalid_op_i, div_zero_i, overflow_i, underflow_i};
         s1_inc_d   = inc_w;
      end
   end

   // Increment, overflow fix-up, bypass and flag generation for the stage-1 operand.
   always_comb begin
      // A mantissa carry-out clears the mantissa and bumps the exponent.
      mant_sum  = {1'b0, s1_op_q.mantissa} + {23'd0, s1_inc_q};
      exp_rnd   = s1_op_q.exponent + {7'd0, mant_sum[23]};
      ix        = |s1_grs_q;
      bypass    = (s1_op_q.exponent == 8'hFF);
      illegal   = !(s1_rm_q inside {RNE, RTZ, RDN, RUP, RMM});
      ovf       = !bypass && ((exp_rnd == 8'hFF) || s1_exc_q[1]);
      to_inf    = (s1_rm_q == RNE) || (s1_rm_q == RMM) ||
                  ((s1_rm_q == RUP) && !s1_op_q.sign) ||
                  ((s1_rm_q == RDN) && s1_op_q.sign);
      res_new   = '{sign: s1_op_q.sign, exponent: exp_rnd, mantissa: mant_sum[22:0]};
      flags_new = '0;
      if (illegal) begin
         res_new      = CANO_NAN;
         flags_new.nv = 1'b1;
      end else if (bypass) begin
         res_new      = s1_op_q;
         flags_new.nv = s1_exc_q[3];
         flags_new.dz = s1_exc_q[2];
         flags_new.uf = s1_exc_q[0];
      end else begin
         if (ovf) begin
            res_new = to_inf ? (s1_op_q.sign ? N_INFTY : P_INFTY)
                             : float_t'({s1_op_q.sign, MAX_FINITE});
         end
         flags_new.nv = s1_exc_q[3];
         flags_new.dz = s1_exc_q[2];
         flags_new.of = ovf;
         flags_new.uf = s1_exc_q[0] | ((res_new.exponent == 8'h00) & ix);
         flags_new.nx = ix | ovf;
      end
   end

   // Stage-2 next state plus the sticky accumulator; clear wins over accumulation.
   always_comb begin
      valid_d   = valid_q;
      result_d  = result_q;
      fflags_d  = fflags_q;
      illegal_d = illegal_q;
      if (clk_en_i) begin
         valid_d   = s1_valid_q;
         result_d  = res_new;
         fflags_d  = s1_valid_q ? flags_new : '0;
         illegal_d = s1_valid_q & illegal;
      end
      acc_d = acc_q;
      if (clear_flags_i) begin
         acc_d = (clk_en_i && valid_q) ? fflags_q : '0;
      end else if (clk_en_i && valid_q) begin
         acc_d = acc_q | fflags_q;
      end
   end

   // Pipeline and accumulator registers, all cleared by the asynchronous reset.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s1_valid_q <= 1'b0;
         s1_op_q    <= '0;
         s1_grs_q   <= '0;
         s1_rm_q    <= RNE;
         s1_exc_q   <= '0;
         s1_inc_q   <= 1'b0;
         valid_q    <= 1'b0;
         result_q   <= '0;
         fflags_q   <= '0;
         acc_q      <= '0;
         illegal_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge value of its source.
         s1_valid_q <= s1_valid_d;
         s1_op_q    <= s1_op_d;
         s1_grs_q   <= s1_grs_d;
         s1_rm_q    <= s1_rm_d;
         s1_exc_q   <= s1_exc_d;
         s1_inc_q   <= s1_inc_d;
         valid_q    <= valid_d;
         result_q   <= result_d;
         fflags_q   <= fflags_d;
         acc_q      <= acc_d;
         illegal_q  <= illegal_d;
      end
   end

   assign result_o     = result_q;
   assign valid_o      = valid_q;
   assign fflags_o     = fflags_q;
   assign fflags_acc_o = acc_q;
   assign illegal_rm_o = illegal_q;

endmodule

// File: tb/tb_fp_round_unit.sv
// Self-checking bench for fp_round_unit: directed cases plus randomized traffic against a model.
module tb_fp_round_unit;
   import Modules_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clk_en = 1'b1;
   logic       valid_i = 1'b0;
   logic [31:0] x_in = '0;
   logic [2:0] grs = '0;
   logic [2:0] rm = '0;
   logic       nv_in = 1'b0, dz_in = 1'b0, of_in = 1'b0, uf_in = 1'b0;
   logic       clear = 1'b0;
   float_t     result_o;
   logic       valid_o;
   fflags_t    fflags_o, fflags_acc_o;
   logic       illegal_rm_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fp_round_unit dut (
      .clk_i           (clk),
      .rst_n_i         (rst_n),
      .clk_en_i        (clk_en),
      .valid_i         (valid_i),
      .to_round_unit_i (float_t'(x_in)),
      .grs_i           (grs),
      .round_mode_i    (rnd_mode_t'(rm)),
      .invalid_op_i    (nv_in),
      .div_zero_i      (dz_in),
      .overflow_i      (of_in),
      .underflow_i     (uf_in),
      .clear_flags_i   (clear),
      .result_o        (result_o),
      .valid_o         (valid_o),
      .fflags_o        (fflags_o),
      .fflags_acc_o    (fflags_acc_o),
      .illegal_rm_o    (illegal_rm_o)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      bit        valid;
      bit [31:0] result;
      bit [4:0]  flags;
      bit        illegal;
   } exp_t;

   // Rounding treated as an integer increment of the 31-bit magnitude.
   function automatic exp_t model(input bit [31:0] x, input bit [2:0] g, input bit [2:0] mode,
                                  input bit nv, input bit dz, input bit ov, input bit un);
      exp_t        e;
      bit          s  = x[31];
      bit          ix = (g != 0);
      bit          up, of, uf, to_inf;
      int unsigned mag = {1'b0, x[30:0]};
      e = '0;
      e.valid = 1'b1;
      if (mode > 3'd4) begin
         e.result = 32'h7FC0_0000;
         e.flags = 5'b10000;
         e.illegal = 1'b1;
         return e;
      end
      if (x[30:23] == 8'hFF) begin
         e.result = x;
         e.flags = {nv, dz, 1'b0, un, 1'b0};
         return e;
      end
      case (mode)
         3'd0:    up = g[2] && (g[1] || g[0] || x[0]);
         3'd1:    up = 1'b0;
         3'd2:    up = s && ix;
         3'd3:    up = !s && ix;
         default: up = g[2];
      endcase
      mag = mag + (up ? 1 : 0);
      of = ov || (mag >= 32'h7F80_0000);
      if (of) begin
         to_inf = (mode == 0) || (mode == 4) || (mode == 3 && !s) || (mode == 2 && s);
         e.result = {s, to_inf ? 31'h7F80_0000 : 31'h7F7F_FFFF};
      end else begin
         e.result = {s, mag[30:0]};
      end
      uf = un || ((e.result[30:23] == 8'h00) && ix);
      e.flags = {nv, dz, of, uf, ix || of};
      return e;
   endfunction

   exp_t       m1 = '0, m2 = '0;
   bit   [4:0] acc_m = '0;

   // Model pipeline: two register stages plus the sticky accumulator.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m1 = '0;
         m2 = '0;
         acc_m = '0;
      end else begin
         if (clear)                    acc_m = (clk_en && m2.valid) ? m2.flags : 5'b0;
         else if (clk_en && m2.valid)  acc_m = acc_m | m2.flags;
         if (clk_en) begin
            m2 = m1;
            m1 = valid_i ? model(x_in, grs, rm, nv_in, dz_in, of_in, uf_in) : exp_t'('0);
         end
      end
   end

   // Compare process: every falling edge once out of the initial reset.
   initial begin
      wait (rst_n === 1'b1);
      forever begin
         @(negedge clk);
         check("valid_o", 32'(valid_o), 32'(m2.valid));
         check("fflags_acc_o", 32'(fflags_acc_o), 32'(acc_m));
         if (m2.valid) begin
            check("result_o", 32'(result_o), m2.result);
            check("fflags_o", 32'(fflags_o), 32'(m2.flags));
            check("illegal_rm_o", 32'(illegal_rm_o), 32'(m2.illegal));
         end else begin
            check("fflags_o bubble", 32'(fflags_o), 32'd0);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic [31:0] x, input logic [2:0] g, input logic [2:0] mode,
                        input logic nv, input logic ov);
      valid_i = 1'b1; x_in = x; grs = g; rm = mode;
      nv_in = nv; dz_in = 1'b0; of_in = ov; uf_in = 1'b0;
   endtask

   // Issue one op into an empty pipeline and pin its result with literal values.
   task automatic directed(input string name, input logic [31:0] x, input logic [2:0] g,
                           input logic [2:0] mode, input logic nv, input logic ov,
                           input logic [31:0] exp_res, input logic [4:0] exp_fl, input logic exp_ill);
      drive(x, g, mode, nv, ov);
      @(posedge clk); #1;
      valid_i = 1'b0;
      check({name, " early"}, 32'(valid_o), 32'd0);
      @(posedge clk); #1;
      check({name, " valid"}, 32'(valid_o), 32'd1);
      check({name, " result"}, 32'(result_o), exp_res);
      check({name, " flags"}, 32'(fflags_o), 32'(exp_fl));
      check({name, " illegal"}, 32'(illegal_rm_o), 32'(exp_ill));
      @(posedge clk); #1;
   endtask

   initial begin
      int r, sel;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check("reset acc", 32'(fflags_acc_o), 32'd0);
      check("reset valid", 32'(valid_o), 32'd0);
      check("reset result", 32'(result_o), 32'd0);

      directed("rne_odd",  32'h3F80_0001, 3'b100, 3'd0, 1'b0, 1'b0, 32'h3F80_0002, 5'b00001, 1'b0);
      directed("rne_even", 32'h3F80_0000, 3'b100, 3'd0, 1'b0, 1'b0, 32'h3F80_0000, 5'b00001, 1'b0);
      directed("carry",    32'h3FFF_FFFF, 3'b001, 3'd3, 1'b0, 1'b0, 32'h4000_0000, 5'b00001, 1'b0);
      directed("ovf_rne",  32'h7F7F_FFFF, 3'b110, 3'd0, 1'b0, 1'b0, 32'h7F80_0000, 5'b00101, 1'b0);
      directed("ovf_rtz",  32'h7F7F_FFFF, 3'b000, 3'd1, 1'b0, 1'b1, 32'h7F7F_FFFF, 5'b00101, 1'b0);
      directed("ovf_rdn",  32'hFF7F_FFFF, 3'b100, 3'd2, 1'b0, 1'b0, 32'hFF80_0000, 5'b00101, 1'b0);
      directed("ovf_rupn", 32'hFF7F_FFFF, 3'b000, 3'd3, 1'b0, 1'b1, 32'hFF7F_FFFF, 5'b00101, 1'b0);
      directed("bypass",   32'h7FC0_0000, 3'b111, 3'd0, 1'b0, 1'b0, 32'h7FC0_0000, 5'b00000, 1'b0);
      directed("ill_rm",   32'h3F80_0000, 3'b000, 3'd5, 1'b0, 1'b0, 32'h7FC0_0000, 5'b10000, 1'b1);
      directed("subnorm",  32'h0000_0001, 3'b010, 3'd1, 1'b0, 1'b0, 32'h0000_0001, 5'b00011, 1'b0);

      // Accumulator: clear, then NX op, then OF op.
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      check("acc cleared", 32'(fflags_acc_o), 32'd0);
      directed("acc_nx", 32'h3F80_0000, 3'b001, 3'd1, 1'b0, 1'b0, 32'h3F80_0000, 5'b00001, 1'b0);
      directed("acc_of", 32'h7F7F_FFFF, 3'b000, 3'd1, 1'b0, 1'b1, 32'h7F7F_FFFF, 5'b00101, 1'b0);
      check("acc nx|of", 32'(fflags_acc_o), 32'h05);
      // Clear coinciding with a valid NV result loads that result's flags.
      drive(32'h3F80_0000, 3'b000, 3'd0, 1'b1, 1'b0);
      @(posedge clk); #1;
      valid_i = 1'b0;
      @(posedge clk); #1;
      check("nv valid", 32'(valid_o), 32'd1);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      check("acc clear+nv", 32'(fflags_acc_o), 32'h10);

      // Stall with two ops in flight.
      drive(32'h3F80_0001, 3'b100, 3'd0, 1'b0, 1'b0);
      @(posedge clk); #1;
      drive(32'h4000_0000, 3'b000, 3'd1, 1'b0, 1'b0);
      @(posedge clk); #1;
      valid_i = 1'b0;
      clk_en = 1'b0;
      check("stall A", 32'(result_o), 32'h3F80_0002);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("stall hold valid", 32'(valid_o), 32'd1);
         check("stall hold A", 32'(result_o), 32'h3F80_0002);
      end
      clk_en = 1'b1;
      @(posedge clk); #1;
      check("release B valid", 32'(valid_o), 32'd1);
      check("release B", 32'(result_o), 32'h4000_0000);
      check("release B flags", 32'(fflags_o), 32'd0);
      @(posedge clk); #1;
      check("release drained", 32'(valid_o), 32'd0);

      // Mid-cycle reset with a valid result on the outputs.
      drive(32'h3F80_0000, 3'b011, 3'd1, 1'b0, 1'b0);
      @(posedge clk); #1;
      valid_i = 1'b0;
      @(posedge clk); #1;
      check("pre-reset valid", 32'(valid_o), 32'd1);
      check("pre-reset acc", 32'(fflags_acc_o), 32'h11);
      #1 rst_n = 1'b0;
      #1;
      check("async rst valid", 32'(valid_o), 32'd0);
      check("async rst acc", 32'(fflags_acc_o), 32'd0);
      check("async rst result", 32'(result_o), 32'd0);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Randomized traffic checked by the compare process.
      for (int c = 0; c < 400; c++) begin
         sel = int'($urandom_range(0, 7));
         case (sel)
            0:       x_in = {1'($urandom), 8'hFF, 23'($urandom)};
            1:       x_in = {1'($urandom), 8'hFE, 23'h7F_FFFF};
            2:       x_in = {1'($urandom), 8'h00, 23'($urandom)};
            3:       x_in = {1'($urandom), 8'($urandom), 23'h7F_FFFF};
            default: x_in = $urandom;
         endcase
         r       = int'($urandom_range(0, 15));
         rm      = (r < 13) ? 3'(r % 5) : 3'(5 + r % 3);
         grs     = 3'($urandom);
         valid_i = ($urandom_range(0, 3) != 0);
         clk_en  = ($urandom_range(0, 4) != 0);
         clear   = ($urandom_range(0, 9) == 0);
         nv_in   = ($urandom_range(0, 7) == 0);
         dz_in   = ($urandom_range(0, 7) == 0);
         of_in   = ($urandom_range(0, 7) == 0);
         uf_in   = ($urandom_range(0, 7) == 0);
         @(posedge clk); #1;
      end
      valid_i = 1'b0;
      clk_en  = 1'b1;
      clear   = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fp_round_unit.md
# fp_round_unit

Final rounding stage of the MicroGT-01 floating-point datapath. Takes the unrounded single-precision result from the arithmetic/magnitude units (the `to_round_unit` bus), together with guard/round/sticky bits and the RISC-V rounding mode. Produces the IEEE-754 rounded result and the per-operation exception flags, and keeps a sticky accumulated `fflags` copy for the CSR file. The pipeline has two stages, gated by the common clock enable.

## Interface
Parameters:
- none; widths are fixed by `float_t` (32-bit) and the RISC-V `fflags` layout.

Ports:
- `clk_i` in 1: clock.
- `rst_n_i` in 1: asynchronous reset, active-low.
- `clk_en_i` in 1: stage advance enable; low freezes both stages.
- `valid_i` in 1: stage-0 inputs are valid.
- `to_round_unit_i` in 32 (`float_t`): unrounded result.
- `grs_i` in 3: {guard, round, sticky}.
- `round_mode_i` in 3 (`rnd_mode_t`): RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100.
- `invalid_op_i`, `div_zero_i`, `overflow_i`, `underflow_i` in 1 each: upstream exception flags.
- `clear_flags_i` in 1: clear accumulated flags.
- `result_o` out 32 (`float_t`): rounded result.
- `valid_o` out 1: `result_o` and `fflags_o` are valid this cycle.
- `fflags_o` out 5: {NV, DZ, OF, UF, NX} for this operation.
- `fflags_acc_o` out 5: sticky OR of `fflags_o` since the last clear.
- `illegal_rm_o` out 1: `round_mode_i` was 101/110/111.

## Operation
- Special bypass: when the exponent is 0xFF (NaN or infinity), the input passes unchanged. No increment is applied and NX=0.
- Inexact: `ix = G|R|S`.
- Increment decision:
  - RNE: `G & (R|S|mant[0])`.
  - RTZ: 0.
  - RDN: `sign & ix`.
  - RUP: `!sign & ix`.
  - RMM: `G`.
- Increment arithmetic:
  - Use a 24-bit add of `{1'b0, mantissa} + inc`.
  - On carry-out, the mantissa becomes 0 and the exponent increments by 1.
- Overflow: applies when the exponent reaches 0xFF after increment, or when `overflow_i` is set.
  - The result is ±infinity for RNE, RMM, RUP (positive sign) and RDN (negative sign).
  - Otherwise the result is ±0x7F7FFFFF (max finite) with the same sign.
  - OF=1 and NX=1.
- Flags:
  - NV = `invalid_op_i`.
  - DZ = `div_zero_i`.
  - UF = `underflow_i | (result exponent==0 & ix)`.
  - NX = `ix` (non-bypass) `| OF`.
- Illegal rounding mode: the result is `CANO_NAN`, NV=1, all other flags 0, and `illegal_rm_o`=1.
- Accumulator:
  - On a `valid_o` cycle, `fflags_acc_o |= fflags_o`.
  - `clear_flags_i` takes priority over accumulation. If clear and `valid_o` occur in the same cycle, the accumulator loads the new `fflags_o`.

## Timing
- Reset (asynchronous, immediate): all pipeline registers and outputs go to 0, including `result_o`, `valid_o`, `fflags_o`, `fflags_acc_o` and `illegal_rm_o`. A reset mid-operation discards in-flight data.
- Stage 1 registers the operand, G/R/S bits, rounding mode, upstream flags, the increment decision and `valid`.
- Stage 2 registers the incremented result, overflow fix-up and flags. It drives the outputs directly from flops.
- Latency:
  - With `clk_en_i` held high, `valid_i` at edge N gives `valid_o` after edge N+2.
  - Throughput is one operation per cycle.
- With `clk_en_i` low:
  - All registers hold, including `valid_o` and the accumulator.
  - `clear_flags_i` still clears the accumulator.
  - No flags are accumulated, because `valid_o` is not advancing.
- Bubbles: `valid_i`=0 propagates as `valid_o`=0. `fflags_o` is 0 whenever `valid_o`=0.

## Structure
- Shared package `Modules_pkg`:
  - `rnd_mode_t` enum.
  - `fflags_t` packed struct {nv, dz, of, uf, nx}.
  - `MAX_FINITE` constant (0x7F7FFFFF magnitude).
  - Reuses the existing `float_t`, `CANO_NAN` and `P_INFTY`/`N_INFTY`.
- One sub-module, `fp_round_decide`: a combinational increment decision from sign, LSB, G/R/S and the rounding mode.

## Test plan
1. RNE tie-to-even:
   - 0x3F800001 with GRS=100 → 0x3F800002, NX=1.
   - 0x3F800000 with GRS=100 → 0x3F800000, NX=1.
2. Mantissa carry: 0x3FFFFFFF with GRS=001, RUP → 0x40000000, `fflags_o`=00001, `valid_o` exactly 2 cycles after `valid_i`.
3. Overflow:
   - 0x7F7FFFFF with GRS=110, RNE → 0x7F800000, flags=00101.
   - 0x7F7FFFFF with `overflow_i`=1, RTZ → 0x7F7FFFFF, flags=00101.
4. Bypass and illegal rounding mode:
   - 0x7FC00000 with GRS=111 → 0x7FC00000, NX=0.
   - `round_mode_i`=101 → `CANO_NAN`, flags=10000, `illegal_rm_o`=1.
5. Stall and reset:
   - Hold `clk_en_i` low for 3 cycles with 2 operations in flight: outputs frozen, no loss, in-order release.
   - Assert `rst_n_i` low mid-cycle: `valid_o` and `fflags_acc_o` drop to 0 before the next edge.
6. Accumulator:
   - Issue an NX operation, then an OF operation: `fflags_acc_o`=00101.
   - Assert `clear_flags_i` together with a valid NV result: `fflags_acc_o`=10000.
